// File: rtl/controller_multicycle.sv
// Multi-cycle RV32I controller: FETCH/DECODE/EXEC/MEM/WB sequencer over one shared memory,
// with retired-instruction counter and memory timeout. Optional macro: ILLEGAL_TRAP_EN.
module controller_multicycle #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_sel,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             MemtoReg,
  output logic             ALUSrc,
  output logic             RegWrite,
  output logic [1:0]       ALUop,
  output logic             lui,
  output logic             auipc,
  output logic             jal,
  output logic             jalr,
  output logic             beq,
  output logic             bne,
  output logic             blt,
  output logic             bge,
  output logic             bltu,
  output logic             bgeu,
  output logic [2:0]       RW_type,
  output logic             busy,
  output logic             illegal,
  output logic             mem_fault,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // The last tolerated wait cycle: missing mem_ready here makes the count reach MEM_TIMEOUT.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       wait_q;
  logic [CNT_W-1:0] instret_q;
  logic             fault_q;
  logic             idle_q;
  logic             fault_set;
  logic             ir_we_c, pc_we_c, reg_write_c;
  logic             flags_en, alu_en, mem_wait;

  logic is_r, is_i, is_load, is_store, is_branch;
  logic is_jal, is_jalr, is_lui, is_auipc, is_known;

  assign is_r      = (opcode == OP_R);
  assign is_i      = (opcode == OP_I);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_lui    = (opcode == OP_LUI);
  assign is_auipc  = (opcode == OP_AUIPC);
  assign is_known  = is_r | is_i | is_load | is_store | is_branch |
                     is_jal | is_jalr | is_lui | is_auipc;

  assign flags_en = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                    (state_q == S_MEM)    || (state_q == S_WB);
  assign alu_en   = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);
  assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    fault_set   = 1'b0;
    mem_req     = 1'b0;
    mem_sel     = 1'b0;
    mem_we      = 1'b0;
    ir_we_c     = 1'b0;
    pc_we_c     = 1'b0;
    reg_write_c = 1'b0;
    MemtoReg    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          fault_set = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
        state_d = is_known ? S_EXEC : S_HALT;
`else
        state_d = S_EXEC;
`endif
      end
      S_EXEC: begin
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_branch || !is_known) begin
          // Branches retire here; unknown opcodes (trap disabled) retire as a NOP.
          pc_we_c = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = is_store;
        if (mem_ready) begin
          pc_we_c = is_store;
          state_d = is_store ? S_FETCH : S_WB;
        end else if (wait_q == WAIT_LAST) begin
          fault_set = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_WB: begin
        reg_write_c = 1'b1;
        MemtoReg    = is_load;
        pc_we_c     = 1'b1;
        state_d     = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Pulses are suppressed on a reset edge so an aborted instruction never retires.
  assign ir_we    = ir_we_c & ~rst;
  assign pc_we    = pc_we_c & ~rst;
  assign RegWrite = reg_write_c & ~rst;

  assign ALUop  = !alu_en   ? 2'b00 :
                  is_r      ? 2'b10 :
                  is_i      ? 2'b01 :
                  is_branch ? 2'b11 : 2'b00;
  assign ALUSrc = alu_en && !is_r && !is_branch;

  assign lui     = flags_en && is_lui;
  assign auipc   = flags_en && is_auipc;
  assign jal     = flags_en && is_jal;
  assign jalr    = flags_en && is_jalr;
  assign beq     = flags_en && is_branch && (func3 == 3'b000);
  assign bne     = flags_en && is_branch && (func3 == 3'b001);
  assign blt     = flags_en && is_branch && (func3 == 3'b100);
  assign bge     = flags_en && is_branch && (func3 == 3'b101);
  assign bltu    = flags_en && is_branch && (func3 == 3'b110);
  assign bgeu    = flags_en && is_branch && (func3 == 3'b111);
  assign RW_type = func3;

  assign busy      = !idle_q && (state_q != S_HALT);
  assign mem_fault = fault_q;
  assign instret   = instret_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
      fault_q   <= 1'b0;
      idle_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      idle_q  <= 1'b0;
      if (state_d != state_q) begin
        wait_q <= '0;
      end else if (mem_wait) begin
        wait_q <= wait_q + 8'd1;
      end
      if (pc_we_c) begin
        instret_q <= instret_q + CNT_W'(1);
      end
      if (fault_set) begin
        fault_q <= 1'b1;
      end
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (state_q == S_DECODE && !is_known) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_controller_multicycle.sv
// Bench for controller_multicycle: table of per-instruction expectations plus hand-written
// sequences for timeout, illegal opcode, counter wrap and reset abort.
module tb_controller_multicycle;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       mem_ready;
  logic       mem_req, mem_sel, mem_we, ir_we, pc_we;
  logic       MemtoReg, ALUSrc, RegWrite;
  logic [1:0] ALUop;
  logic       lui, auipc, jal, jalr, beq, bne, blt, bge, bltu, bgeu;
  logic [2:0] RW_type;
  logic       busy, illegal, mem_fault;
  logic [3:0] instret;
  logic [9:0] flags;

  assign flags = {lui, auipc, jal, jalr, beq, bne, blt, bge, bltu, bgeu};

  controller_multicycle #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_sel(mem_sel), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we),
    .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ALUop(ALUop),
    .lui(lui), .auipc(auipc), .jal(jal), .jalr(jalr), .beq(beq), .bne(bne), .blt(blt),
    .bge(bge), .bltu(bltu), .bgeu(bgeu), .RW_type(RW_type), .busy(busy),
    .illegal(illegal), .mem_fault(mem_fault), .instret(instret)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    int         data_wait;
    int         cycles;
    logic [1:0] aluop;
    bit         chk_src;
    logic       alusrc;
    int         rw_cnt;
    logic       m2r;
    logic       memwe;
    int         memsel_cyc;
    logic [9:0] flags;
  } vec_t;

  typedef struct {
    int         cycles;
    int         irwe_cyc;
    logic [1:0] aluop_e;
    logic       alusrc_e;
    logic [9:0] flags_e;
    logic [9:0] flags_f;
    logic       busy_e;
    logic [2:0] rwtype_e;
    int         rw_cnt;
    logic       m2r;
    logic       memwe_seen;
    int         memsel_cyc;
  } obs_t;

  // Runs one instruction from FETCH until the cycle with pc_we; mem_ready is immediate in
  // FETCH and arrives after data_wait wait cycles in MEM.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int data_wait,
                           output obs_t o);
    int mwait;
    bit done;
    o = '{default: 0};
    opcode = op;
    func3 = f3;
    mwait = 0;
    done = 0;
    while (!done && o.cycles < 40) begin
      o.cycles++;
      if (mem_sel) begin
        mem_ready = (mwait == data_wait);
        mwait++;
      end else begin
        mem_ready = 1'b1;
      end
      #1;
      if (ir_we && o.irwe_cyc == 0) o.irwe_cyc = o.cycles;
      if (o.cycles == 1) o.flags_f = flags;
      if (o.cycles == 3) begin
        o.aluop_e  = ALUop;
        o.alusrc_e = ALUSrc;
        o.flags_e  = flags;
        o.busy_e   = busy;
        o.rwtype_e = RW_type;
      end
      if (RegWrite) begin
        o.rw_cnt++;
        o.m2r = MemtoReg;
      end
      if (mem_req && mem_sel) begin
        o.memsel_cyc++;
        if (mem_we) o.memwe_seen = 1'b1;
      end
      if (pc_we) done = 1;
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    step();
    rst = 1'b0;
    #1;
  endtask

  vec_t       vecs[14];
  obs_t       o;
  logic [3:0] ret_before;
  int         irwe_cnt;

  initial begin
    vecs[0]  = '{"r",      7'b0110011, 3'b000, 0, 4, 2'b10, 1, 1'b0, 1, 1'b0, 1'b0, 0, 10'b0000000000};
    vecs[1]  = '{"i",      7'b0010011, 3'b011, 0, 4, 2'b01, 1, 1'b1, 1, 1'b0, 1'b0, 0, 10'b0000000000};
    vecs[2]  = '{"load",   7'b0000011, 3'b010, 0, 5, 2'b00, 1, 1'b1, 1, 1'b1, 1'b0, 1, 10'b0000000000};
    vecs[3]  = '{"load_w2",7'b0000011, 3'b100, 2, 7, 2'b00, 1, 1'b1, 1, 1'b1, 1'b0, 3, 10'b0000000000};
    vecs[4]  = '{"store",  7'b0100011, 3'b010, 0, 4, 2'b00, 1, 1'b1, 0, 1'b0, 1'b1, 1, 10'b0000000000};
    vecs[5]  = '{"st_w1",  7'b0100011, 3'b000, 1, 5, 2'b00, 1, 1'b1, 0, 1'b0, 1'b1, 2, 10'b0000000000};
    vecs[6]  = '{"beq",    7'b1100011, 3'b000, 0, 3, 2'b11, 1, 1'b0, 0, 1'b0, 1'b0, 0, 10'b0000100000};
    vecs[7]  = '{"bge",    7'b1100011, 3'b101, 0, 3, 2'b11, 1, 1'b0, 0, 1'b0, 1'b0, 0, 10'b0000000100};
    vecs[8]  = '{"bltu",   7'b1100011, 3'b110, 0, 3, 2'b11, 1, 1'b0, 0, 1'b0, 1'b0, 0, 10'b0000000010};
    vecs[9]  = '{"bne",    7'b1100011, 3'b001, 0, 3, 2'b11, 1, 1'b0, 0, 1'b0, 1'b0, 0, 10'b0000010000};
    vecs[10] = '{"jal",    7'b1101111, 3'b000, 0, 4, 2'b00, 0, 1'b0, 1, 1'b0, 1'b0, 0, 10'b0010000000};
    vecs[11] = '{"jalr",   7'b1100111, 3'b000, 0, 4, 2'b00, 0, 1'b0, 1, 1'b0, 1'b0, 0, 10'b0001000000};
    vecs[12] = '{"lui",    7'b0110111, 3'b000, 0, 4, 2'b00, 0, 1'b0, 1, 1'b0, 1'b0, 0, 10'b1000000000};
    vecs[13] = '{"auipc",  7'b0010111, 3'b000, 0, 4, 2'b00, 0, 1'b0, 1, 1'b0, 1'b0, 0, 10'b0100000000};

    opcode = 7'd0;
    func3 = 3'd0;
    rst = 1'b1;
    mem_ready = 1'b0;
    step();
    do_reset();

    // Reset state, sampled in the first FETCH cycle with mem_ready low.
    check("rst_instret", 32'(instret), 32'd0);
    check("rst_fault", 32'(mem_fault), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_pulses", 32'({ir_we, pc_we, RegWrite}), 32'd0);
    check("rst_mem_req", 32'({mem_req, mem_sel, mem_we}), 32'b100);
    check("rst_flags", 32'(flags), 32'd0);

    for (int i = 0; i < 14; i++) begin
      ret_before = instret;
      run_instr(vecs[i].op, vecs[i].f3, vecs[i].data_wait, o);
      check({vecs[i].name, "_cycles"}, 32'(o.cycles), 32'(vecs[i].cycles));
      check({vecs[i].name, "_irwe_cyc"}, 32'(o.irwe_cyc), 32'd1);
      check({vecs[i].name, "_aluop"}, 32'(o.aluop_e), 32'(vecs[i].aluop));
      if (vecs[i].chk_src) check({vecs[i].name, "_alusrc"}, 32'(o.alusrc_e), 32'(vecs[i].alusrc));
      check({vecs[i].name, "_flags_exec"}, 32'(o.flags_e), 32'(vecs[i].flags));
      check({vecs[i].name, "_flags_fetch"}, 32'(o.flags_f), 32'd0);
      check({vecs[i].name, "_busy"}, 32'(o.busy_e), 32'd1);
      check({vecs[i].name, "_rw_type"}, 32'(o.rwtype_e), 32'(vecs[i].f3));
      check({vecs[i].name, "_regwrite"}, 32'(o.rw_cnt), 32'(vecs[i].rw_cnt));
      check({vecs[i].name, "_memtoreg"}, 32'(o.m2r), 32'(vecs[i].m2r));
      check({vecs[i].name, "_mem_we"}, 32'(o.memwe_seen), 32'(vecs[i].memwe));
      check({vecs[i].name, "_memsel_cyc"}, 32'(o.memsel_cyc), 32'(vecs[i].memsel_cyc));
      check({vecs[i].name, "_instret"}, 32'(instret), 32'(ret_before + 4'd1));
    end

    // Three FETCH wait cycles, then mem_ready on the last tolerated cycle: no fault.
    opcode = 7'b0110011;
    func3 = 3'b000;
    mem_ready = 1'b0;
    repeat (3) step();
    mem_ready = 1'b1;
    #1;
    check("late_ready_ir_we", 32'(ir_we), 32'd1);
    step();
    check("late_ready_fault", 32'(mem_fault), 32'd0);
    check("late_ready_busy", 32'(busy), 32'd1);
    step();
    step();
    check("late_ready_wb_pc_we", 32'({pc_we, RegWrite}), 32'b11);
    step();
    mem_ready = 1'b0;

    // mem_ready held low for four FETCH cycles: fault and HALT.
    ret_before = instret;
    repeat (3) step();
    check("timeout_pre_fault", 32'(mem_fault), 32'd0);
    step();
    check("timeout_fault", 32'(mem_fault), 32'd1);
    check("timeout_halt", 32'({mem_req, busy}), 32'd0);
    mem_ready = 1'b1;
    irwe_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (ir_we || mem_req || pc_we) irwe_cnt++;
      step();
    end
    check("halt_ignores_ready", 32'(irwe_cnt), 32'd0);
    check("halt_instret", 32'(instret), 32'(ret_before));
    do_reset();
    check("fault_cleared", 32'(mem_fault), 32'd0);
    check("fault_rst_mem_req", 32'(mem_req), 32'd1);

    // Unrecognised opcode.
    ret_before = instret;
`ifdef ILLEGAL_TRAP_EN
    opcode = 7'b1111111;
    mem_ready = 1'b1;
    step();
    step();
    mem_ready = 1'b0;
    #1;
    check("illegal_flag", 32'(illegal), 32'd1);
    check("illegal_halt", 32'({mem_req, busy}), 32'd0);
    check("illegal_instret", 32'(instret), 32'(ret_before));
    do_reset();
`else
    run_instr(7'b1111111, 3'b000, 0, o);
    check("nop_cycles", 32'(o.cycles), 32'd3);
    check("nop_regwrite", 32'(o.rw_cnt), 32'd0);
    check("nop_instret", 32'(instret), 32'(ret_before + 4'd1));
    check("nop_illegal", 32'(illegal), 32'd0);
    do_reset();
`endif

    // Sixteen stores wrap the 4-bit counter.
    for (int k = 0; k < 16; k++) begin
      run_instr(7'b0100011, 3'b010, 0, o);
      if (k == 14) check("wrap_15", 32'(instret), 32'd15);
    end
    check("wrap_0", 32'(instret), 32'd0);

    // Reset while a store is writing in MEM.
    ret_before = instret;
    opcode = 7'b0100011;
    mem_ready = 1'b1;
    repeat (3) step();
    mem_ready = 1'b0;
    #1;
    check("abort_in_mem", 32'({mem_sel, mem_we}), 32'b11);
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("abort_no_pc_we", 32'({pc_we, RegWrite}), 32'd0);
    step();
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("abort_fetch", 32'({mem_req, mem_sel, mem_we}), 32'b100);
    check("abort_instret", 32'(instret), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
